// File: rtl/reg_file.sv
// reg_file: 32 x DATA_WIDTH register file with two combinational read ports,
// one synchronous write port and a self-clearing sequence after reset.
//
// Register 0 reads as zero and ignores writes. After reset is released the
// block walks registers 1..31 writing zero, one per clock, holding busy high
// for exactly 31 edges. While busy is high both read ports return zero and
// writes from the core are dropped.
//
// Optional feature (compile-time macro REGFILE_BYPASS_EN):
//   defined   - a write in flight to the register being read is forwarded to
//               the read port in the same cycle (write-through).
//   undefined - reads show the stored value until after the write edge.
//
// Parameters:
//   DATA_WIDTH  width of each register and of all data ports (default 32)
//
// Ports:
//   clk        in   1           sole clock, rising edge
//   reset      in   1           synchronous active-high reset, starts clear
//   readReg1   in   5           read port 1 register index
//   readReg2   in   5           read port 2 register index
//   writeReg   in   5           write port register index
//   writeData  in   DATA_WIDTH  write data
//   regWrite   in   1           write enable
//   readData1  out  DATA_WIDTH  contents of readReg1
//   readData2  out  DATA_WIDTH  contents of readReg2
//   busy       out  1           high while the clear sequence runs

module reg_file #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4:0]            readReg1,
    input  logic [4:0]            readReg2,
    input  logic [4:0]            writeReg,
    input  logic [DATA_WIDTH-1:0] writeData,
    input  logic                  regWrite,
    output logic [DATA_WIDTH-1:0] readData1,
    output logic [DATA_WIDTH-1:0] readData2,
    output logic                  busy
);

    typedef enum logic [0:0] {
        StClear,
        StReady
    } state_e;

    state_e     state_q, state_d;
    logic [4:0] clr_ptr_q, clr_ptr_d;

    logic [DATA_WIDTH-1:0] regs [32];

    logic                  user_we;
    logic                  mem_we;
    logic [4:0]            mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    // busy is decoded purely from the state register.
    assign busy = (state_q == StClear);

    // Core write request that is allowed to reach the array.
    assign user_we = regWrite && !busy && (writeReg != 5'd0);

    // ------------------------------------------------------------------
    // Clear-sequence FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        unique case (state_q)
            StClear: begin
                if (clr_ptr_q == 5'd31) begin
                    // Last register cleared; pointer parks at 31.
                    state_d = StReady;
                end else begin
                    clr_ptr_d = clr_ptr_q + 5'd1;
                end
            end
            StReady: begin
                state_d = StReady;
            end
            default: begin
                state_d   = StClear;
                clr_ptr_d = 5'd1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StClear;
            clr_ptr_q <= 5'd1;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    // ------------------------------------------------------------------
    // Storage write port, shared between the clear walker and the core
    // ------------------------------------------------------------------
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = writeReg;
        mem_wdata = writeData;
        if (!reset) begin
            if (busy) begin
                mem_we    = 1'b1;
                mem_waddr = clr_ptr_q;
                mem_wdata = '0;
            end else if (user_we) begin
                mem_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            regs[mem_waddr] <= mem_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Combinational read ports
    // ------------------------------------------------------------------
`ifdef REGFILE_BYPASS_EN
    logic bypass_ok;
    assign bypass_ok = regWrite && !busy && (writeReg != 5'd0);
`endif

    always_comb begin
        readData1 = '0;
        if (!busy && (readReg1 != 5'd0)) begin
            readData1 = regs[readReg1];
`ifdef REGFILE_BYPASS_EN
            if (bypass_ok && (writeReg == readReg1)) begin
                readData1 = writeData;
            end
`endif
        end
    end

    always_comb begin
        readData2 = '0;
        if (!busy && (readReg2 != 5'd0)) begin
            readData2 = regs[readReg2];
`ifdef REGFILE_BYPASS_EN
            if (bypass_ok && (writeReg == readReg2)) begin
                readData2 = writeData;
            end
`endif
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: self-checking bench for reg_file.
// Keeps a plain array model of the 32 registers plus a ready flag, drives
// directed and $urandom stimulus, and compares read ports and busy against it.
// Honours the REGFILE_BYPASS_EN macro when predicting same-cycle reads.

module tb_reg_file;

    localparam int unsigned DW = 32;

    logic          clk;
    logic          reset;
    logic [4:0]    readReg1;
    logic [4:0]    readReg2;
    logic [4:0]    writeReg;
    logic [DW-1:0] writeData;
    logic          regWrite;
    logic [DW-1:0] readData1;
    logic [DW-1:0] readData2;
    logic          busy;

    int checks = 0;
    int fails  = 0;

    // Reference model: register contents as the core should see them.
    logic [DW-1:0] model [32];

`ifdef REGFILE_BYPASS_EN
    localparam bit Bypass = 1'b1;
`else
    localparam bit Bypass = 1'b0;
`endif

    reg_file #(
        .DATA_WIDTH(DW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .readReg1 (readReg1),
        .readReg2 (readReg2),
        .writeReg (writeReg),
        .writeData(writeData),
        .regWrite (regWrite),
        .readData1(readData1),
        .readData2(readData2),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and step just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model[i] = '0;
    endtask

    // Walk the 31 busy cycles, checking busy and zeroed reads each cycle.
    // Optionally keep hammering a write that must be dropped.
    task automatic run_clear(input bit with_write);
        for (int i = 0; i < 31; i++) begin
            readReg1 = 5'($urandom_range(0, 31));
            readReg2 = 5'($urandom_range(0, 31));
            if (with_write) begin
                regWrite  = 1'b1;
                writeReg  = 5'd3;
                writeData = 32'h1;
            end
            #1;
            checks++;
            if (busy !== 1'b1) begin
                fails++;
                $display("FAIL clear_busy cycle %0d: busy=%b want 1", i, busy);
            end
            checks++;
            if (readData1 !== '0 || readData2 !== '0) begin
                fails++;
                $display("FAIL clear_read cycle %0d: rd1=%h rd2=%h want 0", i, readData1,
                         readData2);
            end
            tick();
        end
        regWrite = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL clear_done: busy=%b want 0 after 31 edges", busy);
        end
        model_clear();
    endtask

    task automatic do_write(input logic [4:0] idx, input logic [DW-1:0] val);
        regWrite  = 1'b1;
        writeReg  = idx;
        writeData = val;
        tick();
        regWrite = 1'b0;
        if (idx != 5'd0) model[idx] = val;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        run_clear(1'b0);
    endtask

    task automatic test_write_read();
        do_write(5'd5, 32'hDEADBEEF);
        readReg1 = 5'd5;
        readReg2 = 5'd6;
        #1;
        checks++;
        if (readData1 !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL write_read r5: got %h want deadbeef", readData1);
        end
        checks++;
        if (readData2 !== model[6]) begin
            fails++;
            $display("FAIL write_read r6: got %h want %h", readData2, model[6]);
        end
    endtask

    task automatic test_reg0();
        do_write(5'd0, 32'hFFFFFFFF);
        readReg1 = 5'd0;
        readReg2 = 5'd0;
        #1;
        checks++;
        if (readData1 !== '0 || readData2 !== '0) begin
            fails++;
            $display("FAIL reg0: rd1=%h rd2=%h want 0", readData1, readData2);
        end
    endtask

    task automatic test_bypass();
        logic [DW-1:0] exp_now;
        exp_now   = Bypass ? 32'h12345678 : model[7];
        regWrite  = 1'b1;
        writeReg  = 5'd7;
        writeData = 32'h12345678;
        readReg1  = 5'd7;
        readReg2  = 5'd7;
        #1;
        checks++;
        if (readData1 !== exp_now) begin
            fails++;
            $display("FAIL bypass_same_cycle: got %h want %h", readData1, exp_now);
        end
        checks++;
        if (readData2 !== readData1) begin
            fails++;
            $display("FAIL same_index: rd2=%h want rd1=%h", readData2, readData1);
        end
        tick();
        regWrite = 1'b0;
        model[7] = 32'h12345678;
        #1;
        checks++;
        if (readData1 !== 32'h12345678 || readData2 !== 32'h12345678) begin
            fails++;
            $display("FAIL bypass_next_cycle: rd1=%h rd2=%h want 12345678", readData1,
                     readData2);
        end
    endtask

    task automatic test_reset_mid_clear();
        do_write(5'd9, 32'hA5A5A5A5);
        readReg1 = 5'd9;
        #1;
        checks++;
        if (readData1 !== 32'hA5A5A5A5) begin
            fails++;
            $display("FAIL r9_written: got %h want a5a5a5a5", readData1);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        // Nine clear edges, then reset on the tenth.
        for (int i = 0; i < 9; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        run_clear(1'b0);
        readReg1 = 5'd9;
        #1;
        checks++;
        if (readData1 !== '0) begin
            fails++;
            $display("FAIL r9_after_restart: got %h want 0", readData1);
        end
    endtask

    task automatic test_busy_write();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        run_clear(1'b1);
        readReg1 = 5'd3;
        #1;
        checks++;
        if (readData1 !== '0) begin
            fails++;
            $display("FAIL busy_write_dropped: r3=%h want 0", readData1);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] e1, e2;
        for (int i = 0; i < 300; i++) begin
            readReg1  = 5'($urandom_range(0, 31));
            readReg2  = ($urandom_range(0, 3) == 0) ? readReg1 : 5'($urandom_range(0, 31));
            writeReg  = ($urandom_range(0, 3) == 0) ? readReg1 : 5'($urandom_range(0, 31));
            writeData = $urandom();
            regWrite  = 1'($urandom_range(0, 1));
            e1 = (readReg1 == 5'd0) ? '0 : model[readReg1];
            e2 = (readReg2 == 5'd0) ? '0 : model[readReg2];
            if (Bypass && regWrite && writeReg != 5'd0) begin
                if (writeReg == readReg1) e1 = writeData;
                if (writeReg == readReg2) e2 = writeData;
            end
            #1;
            checks++;
            if (readData1 !== e1 || readData2 !== e2 || busy !== 1'b0) begin
                fails++;
                $display("FAIL random %0d: rr1=%0d rd1=%h want %h rr2=%0d rd2=%h want %h busy=%b",
                         i, readReg1, readData1, e1, readReg2, readData2, e2, busy);
            end
            tick();
            if (regWrite && writeReg != 5'd0) model[writeReg] = writeData;
        end
        regWrite = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        regWrite  = 1'b0;
        readReg1  = 5'd0;
        readReg2  = 5'd0;
        writeReg  = 5'd0;
        writeData = '0;
        model_clear();

        test_reset();
        test_write_read();
        test_reg0();
        test_bypass();
        test_random();
        test_reset_mid_clear();
        test_busy_write();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
